// File: rtl/coefficient_loader_if.sv
// coefficient_loader_if
//   Bundles the coefficient-load stream and the tap read port between the
//   coefficient source / FIR MAC side (master) and the loader (slave).
//   Stream:  loadStart, coefficientValid, coefficientIn  (master -> slave)
//   Read:    readAddr (master -> slave), readData (slave -> master)
//   Status:  loadBusy, coefficientsReady, overrunFlag, loadCount (slave -> master)
interface coefficient_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  loadStart;
  logic                  coefficientValid;
  logic [DATA_WIDTH-1:0] coefficientIn;
  logic [ADDR_WIDTH-1:0] readAddr;
  logic [DATA_WIDTH-1:0] readData;
  logic                  loadBusy;
  logic                  coefficientsReady;
  logic                  overrunFlag;
  logic [ADDR_WIDTH:0]   loadCount;

  modport master (
    output loadStart, coefficientValid, coefficientIn, readAddr,
    input  readData, loadBusy, coefficientsReady, overrunFlag, loadCount
  );

  modport slave (
    input  loadStart, coefficientValid, coefficientIn, readAddr,
    output readData, loadBusy, coefficientsReady, overrunFlag, loadCount
  );
endinterface

// File: rtl/coefficient_loader.sv
// coefficient_loader
//   Receive end of the FIR coefficient stream. Stores LENGTH signed
//   coefficients in arrival order, flags the bank complete, and serves a
//   registered (1-cycle) random-access read port to the MAC datapath.
//   clock    : system clock, posedge
//   reset_n  : asynchronous active-low reset, clears all state and the bank
//   bus      : coefficient_loader_if slave (stream in, read port, status out)
module coefficient_loader #(
  parameter int LENGTH     = 20,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  coefficient_loader_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  localparam logic [ADDR_WIDTH:0] LEN_C  = (ADDR_WIDTH+1)'(LENGTH);
  localparam logic [ADDR_WIDTH:0] LAST_C = (ADDR_WIDTH+1)'(LENGTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ready_q, ready_d;
  logic                  overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] bank_q [LENGTH];
  logic [DATA_WIDTH-1:0] bank_d [LENGTH];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    bank_d    = bank_q;
    rdata_d   = '0;

    // Read from the pre-write bank: same-cycle write to the same index
    // returns the old value.
    if ({1'b0, bus.readAddr} < LEN_C) rdata_d = bank_q[bus.readAddr];

    if (bus.loadStart) begin
      // Restart wins over everything, including a beat in the same cycle,
      // which becomes entry 0 of the new load.
      state_d   = LOAD;
      count_d   = '0;
      ready_d   = 1'b0;
      overrun_d = 1'b0;
      if (bus.coefficientValid) begin
        bank_d[0] = bus.coefficientIn;
        count_d   = (ADDR_WIDTH+1)'(1);
      end
    end else begin
      case (state_q)
        LOAD: begin
          if (bus.coefficientValid && count_q < LEN_C) begin
            bank_d[count_q[ADDR_WIDTH-1:0]] = bus.coefficientIn;
            count_d = count_q + 1'b1;
            if (count_q == LAST_C) begin
              state_d = DONE;
              ready_d = 1'b1;
            end
          end
        end
        default: begin
          // IDLE / DONE: bank is not accepting, beats are dropped and flagged.
          if (bus.coefficientValid) overrun_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      rdata_q   <= '0;
      for (int i = 0; i < LENGTH; i++) bank_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
      rdata_q   <= rdata_d;
      bank_q    <= bank_d;
    end
  end

  assign bus.readData          = rdata_q;
  assign bus.loadBusy          = (state_q == LOAD);
  assign bus.coefficientsReady = ready_q;
  assign bus.overrunFlag       = overrun_q;
  assign bus.loadCount         = count_q;

endmodule

// File: tb/tb_coefficient_loader.sv
// tb_coefficient_loader
//   Drives directed and random coefficient loads into coefficient_loader and
//   compares every output each cycle against a behavioural bank model.
module tb_coefficient_loader;
  localparam int LEN = 20;

  logic clock;
  logic reset_n;
  int   errs   = 0;
  int   checks = 0;

  coefficient_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bif ();

  coefficient_loader #(.LENGTH(LEN), .DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: the bank contents plus load status.
  int m_bank [LEN];
  int m_cnt;
  bit m_busy, m_rdy, m_ovr;

  int stream [LEN] = '{34, 34, 0, 49, 125, -77, -51, 8, 97, 109,
                       -91, -3, 9, 1, 59, 75, 19, 58, -97, 10};

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_bank[i]) m_bank[i] = 0;
    m_cnt = 0; m_busy = 0; m_rdy = 0; m_ovr = 0;
  endtask

  task automatic check_outputs(input int exp_rd);
    chk("readData", $signed(bif.readData), exp_rd);
    chk("loadBusy", bif.loadBusy, m_busy);
    chk("coefficientsReady", bif.coefficientsReady, m_rdy);
    chk("overrunFlag", bif.overrunFlag, m_ovr);
    chk("loadCount", bif.loadCount, m_cnt);
  endtask

  // One clock: apply inputs, advance model at the edge, check #1 later.
  task automatic cycle(input bit st, input bit v, input int d, input int a);
    int exp_rd;
    logic [7:0] d8;
    logic [4:0] a5;
    d8 = d[7:0];
    a5 = a[4:0];
    bif.loadStart        = st;
    bif.coefficientValid = v;
    bif.coefficientIn    = d8;
    bif.readAddr         = a5;
    exp_rd = (a < LEN) ? m_bank[a] : 0;
    @(posedge clock);
    if (st) begin
      m_busy = 1; m_rdy = 0; m_ovr = 0; m_cnt = 0;
      if (v) begin m_bank[0] = d; m_cnt = 1; end
    end else if (v) begin
      if (m_busy && m_cnt < LEN) begin
        m_bank[m_cnt] = d;
        m_cnt++;
        if (m_cnt == LEN) begin m_busy = 0; m_rdy = 1; end
      end else begin
        m_ovr = 1;
      end
    end
    #1;
    check_outputs(exp_rd);
  endtask

  function automatic int rnd_data();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic read_all();
    for (int a = 0; a < LEN; a++) cycle(0, 0, rnd_data(), a);
  endtask

  initial begin
    reset_n = 1'b1;
    bif.loadStart = 0; bif.coefficientValid = 0;
    bif.coefficientIn = '0; bif.readAddr = '0;
    model_reset();
    #2 reset_n = 1'b0;

    // 1: reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      bif.loadStart        = 1'($urandom_range(0, 1));
      bif.coefficientValid = 1'($urandom_range(0, 1));
      bif.coefficientIn    = 8'($urandom_range(0, 255));
      bif.readAddr         = 5'($urandom_range(0, 31));
      @(posedge clock); #1;
      check_outputs(0);
    end
    @(negedge clock) reset_n = 1'b1;
    read_all();

    // 2: nominal back-to-back load, then 4: overrun beat
    cycle(1, 0, 0, 0);
    for (int i = 0; i < LEN; i++) cycle(0, 1, stream[i], i);
    chk("t2_ready", bif.coefficientsReady, 1);
    chk("t2_count", bif.loadCount, LEN);
    read_all();
    cycle(0, 1, 55, 0);
    chk("t4_overrun", bif.overrunFlag, 1);
    cycle(0, 0, 0, 0);
    chk("t4_bank0", $signed(bif.readData), 34);
    cycle(0, 0, 0, 5);
    chk("t2_addr5", $signed(bif.readData), -77);
    cycle(0, 0, 0, 18);
    chk("t2_addr18", $signed(bif.readData), -97);

    // 3: gapped load with junk data on idle beats
    cycle(1, 0, 0, 0);
    for (int i = 0; i < LEN; i++) begin
      cycle(0, 1, stream[i], $urandom_range(0, 31));
      if (i != LEN - 1) cycle(0, 0, rnd_data(), $urandom_range(0, 31));
    end
    read_all();

    // 5: restart mid-load with a simultaneous beat
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 1, rnd_data(), i);
    cycle(1, 1, -128, 0);
    chk("t5_count", bif.loadCount, 1);
    chk("t5_ready", bif.coefficientsReady, 0);
    chk("t5_overrun", bif.overrunFlag, 0);
    cycle(0, 0, 0, 0);
    chk("t5_bank0", $signed(bif.readData), -128);
    for (int i = 0; i < LEN - 1; i++) cycle(0, 1, rnd_data(), $urandom_range(0, 31));
    chk("t5_ready_end", bif.coefficientsReady, 1);

    // 6: async reset between edges mid-load
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, rnd_data(), i);
    bif.coefficientValid = 0; bif.loadStart = 0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs(0);
    #3 reset_n = 1'b1;
    read_all();

    // Random traffic, including out-of-range reads
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            rnd_data(), $urandom_range(0, 31));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
